// File: rtl/m32_8_pkg.sv
// Shared definitions for the m32_8 word-to-byte serializer.
// Holds the FSM state encoding, the default idle fill byte, the FIFO depth
// and the debug view struct exported by the top.
package m32_8_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [7:0]  IDLE_BYTE_DEFAULT = 8'hBC;
    localparam int unsigned FIFO_DEPTH        = 2;

    // Debug snapshot of the control state, for checkers and waveforms.
    typedef struct packed {
        state_e     state;
        logic [1:0] byte_cnt;
        logic [1:0] count;
    } dbg_t;

    // Select one byte of a word, byte 0 being the most significant.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word FIFO with occupancy count and a registered head view.
// A push while full and a pop while empty are ignored, so the caller may
// gate them loosely; data storage carries no reset value.
module word_fifo2
    import m32_8_pkg::*;
(
    input  logic        clk_4f,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] data_in,
    output logic [1:0]  count,
    output logic [31:0] head
);

    logic [31:0] mem [FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Fullness is judged on the registered count, so a pop on the same edge
    // never frees a slot for a push while full.
    assign do_push = push && (count != 2'(FIFO_DEPTH));
    assign do_pop  = pop  && (count != 2'd0);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Word storage write.
    always_ff @(posedge clk_4f) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/m32_8.sv
// m32_8: 32-bit word to 8-bit byte stream serializer, MSB byte first.
//
// Handshake: a word is taken on a rising edge where valid_input=1 and
// ready_32=1; ready_32 is decoded from the registered FIFO count only, so
// upstream must hold data_input/valid_input stable until it sees both high
// at an edge. data_8/valid_8 are plain flop outputs with no backpressure.
//
// Build option: define M32_8_IDLE_FILL_EN to drive IDLE_BYTE on data_8 in
// cycles without payload; otherwise data_8 is 8'h00 whenever valid_8=0.
module m32_8
    import m32_8_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [31:0] data_input,
    input  logic        valid_input,
    output logic        ready_32,
    output logic [7:0]  data_8,
    output logic        valid_8,
    output dbg_t        dbg
);

`ifdef M32_8_IDLE_FILL_EN
    localparam logic [7:0] IDLE_OUT = IDLE_BYTE;
`else
    // The parameter stays in the interface so both builds share one header.
    localparam logic [7:0] IDLE_OUT = IDLE_BYTE & 8'h00;
`endif

    state_e      state;
    state_e      next_state;
    logic [1:0]  byte_cnt;
    logic [1:0]  next_byte_cnt;
    logic [1:0]  count;
    logic [31:0] head;
    logic        push;
    logic        pop;
    logic [7:0]  next_data;
    logic        next_valid;

    assign ready_32 = (count != 2'(FIFO_DEPTH));
    assign push     = valid_input && ready_32;
    assign dbg      = '{state: state, byte_cnt: byte_cnt, count: count};

    word_fifo2 u_fifo (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (data_input),
        .count   (count),
        .head    (head)
    );

    // Next-state, pop and next output byte from the current state.
    always_comb begin
        next_state    = state;
        next_byte_cnt = byte_cnt;
        pop           = 1'b0;
        next_valid    = 1'b0;
        next_data     = IDLE_OUT;
        case (state)
            IDLE: begin
                // In IDLE the FIFO is empty, so a push is what makes it non-empty.
                if (push) begin
                    next_state    = SEND;
                    next_byte_cnt = 2'd0;
                end
            end
            SEND: begin
                next_valid    = 1'b1;
                next_data     = word_byte(head, byte_cnt);
                next_byte_cnt = byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    pop = 1'b1;
                    // Keep streaming if a second word is buffered or arrives now.
                    if ((count == 2'd1) && !push) next_state = IDLE;
                end
            end
            default: begin
                next_state    = IDLE;
                next_byte_cnt = 2'd0;
            end
        endcase
    end

    // State, byte counter and registered output stream.
    always_ff @(posedge clk_4f or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            data_8   <= 8'h00;
            valid_8  <= 1'b0;
        end else begin
            state    <= next_state;
            byte_cnt <= next_byte_cnt;
            data_8   <= next_data;
            valid_8  <= next_valid;
        end
    end

endmodule

// File: tb/tb_m32_8.sv
module tb_m32_8;
  import m32_8_pkg::*;

`ifdef M32_8_IDLE_FILL_EN
  localparam logic [7:0] IDLE_FILL = 8'hBC;
`else
  localparam logic [7:0] IDLE_FILL = 8'h00;
`endif

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [31:0] data_input;
  logic        valid_input;
  logic        ready_32;
  logic [7:0]  data_8;
  logic        valid_8;
  dbg_t        dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: bytes expected on the stream, in order.
  logic [7:0]  exp_q[$];
  // Reference model: words held by the buffer and position in the head word.
  logic [31:0] wq[$];
  int          m_pos = 0;
  logic        m_valid_exp = 1'b0;
  logic        m_seen_edge = 1'b0;
  logic        m_accepted = 1'b0;

  m32_8 dut (
    .clk_4f      (clk_4f),
    .reset       (reset),
    .data_input  (data_input),
    .valid_input (valid_input),
    .ready_32    (ready_32),
    .data_8      (data_8),
    .valid_8     (valid_8),
    .dbg         (dbg)
  );

  // Clock
  always #5 clk_4f = ~clk_4f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the stream emits bytes whenever the buffer is non-empty,
  // one byte per edge, popping a word after its fourth byte; words are taken
  // whenever fewer than two are held.
  always @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      wq.delete();
      exp_q.delete();
      m_pos       = 0;
      m_valid_exp = 1'b0;
      m_seen_edge = 1'b0;
      m_accepted  = 1'b0;
    end else begin
      m_accepted = valid_input && (wq.size() < 2);
      if (wq.size() > 0) begin
        m_valid_exp = 1'b1;
        if (m_pos == 3) begin
          void'(wq.pop_front());
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end else begin
        m_valid_exp = 1'b0;
      end
      if (m_accepted) begin
        wq.push_back(data_input);
        exp_q.push_back(data_input[31:24]);
        exp_q.push_back(data_input[23:16]);
        exp_q.push_back(data_input[15:8]);
        exp_q.push_back(data_input[7:0]);
      end
      m_seen_edge = 1'b1;
    end
  end

  // Monitor: compare outputs on the falling edge.
  always @(negedge clk_4f) begin
    if (!reset) begin
      check("rst_valid", {31'b0, valid_8}, 32'd0);
      check("rst_data", {24'b0, data_8}, 32'd0);
      check("rst_ready", {31'b0, ready_32}, 32'd1);
    end else begin
      check("ready", {31'b0, ready_32}, (wq.size() < 2) ? 32'd1 : 32'd0);
      check("count", {30'b0, dbg.count}, wq.size());
      check("state", {31'b0, dbg.state}, (wq.size() > 0) ? {31'b0, SEND} : {31'b0, IDLE});
      check("valid", {31'b0, valid_8}, {31'b0, m_valid_exp});
      if (valid_8) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL byte_unexpected actual=%0h expected=none time=%0t", data_8, $time);
        end else begin
          check("byte", {24'b0, data_8}, {24'b0, exp_q.pop_front()});
        end
      end else begin
        check("idle_data", {24'b0, data_8}, m_seen_edge ? {24'b0, IDLE_FILL} : 32'd0);
      end
    end
  end

  // Drivers
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_4f);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    int budget;
    budget      = 0;
    valid_input = 1'b1;
    data_input  = w;
    do begin
      @(posedge clk_4f);
      #1;
      budget++;
    end while (!m_accepted && budget < 20);
    if (!m_accepted) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted word=%0h", w);
    end
    valid_input = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || wq.size() != 0) && budget < 200) begin
      @(posedge clk_4f);
      #1;
      budget++;
    end
    if (exp_q.size() != 0 || wq.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0", exp_q.size());
    end
    idle(3);
  endtask

  // Stimulus
  initial begin
    logic [31:0] w;
    reset       = 1'b0;
    valid_input = 1'b0;
    data_input  = 32'h0;
    repeat (3) @(posedge clk_4f);
    #2 reset = 1'b1;
    idle(3);

    // Single word then idle.
    send_word(32'hDEADBEEF);
    idle(8);

    // Back-to-back words; buffer full right after the second accept.
    send_word(32'h01020304);
    send_word(32'hA0B0C0D0);
    check("b2b_ready_full", {31'b0, ready_32}, 32'd0);
    wait_drain();

    // Push on the pop edge with one word held.
    send_word(32'h55667788);
    idle(3);
    send_word(32'h11223344);
    check("pushpop_count", {30'b0, dbg.count}, 32'd1);
    wait_drain();

    // Valid held high for 12 cycles with incrementing words.
    w           = 32'h10000000;
    valid_input = 1'b1;
    for (int i = 0; i < 12; i++) begin
      data_input = w;
      @(posedge clk_4f);
      #1;
      if (m_accepted) w = w + 32'd1;
    end
    valid_input = 1'b0;
    wait_drain();

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      valid_input = ($urandom_range(0, 3) != 0);
      data_input  = $urandom;
      @(posedge clk_4f);
      #1;
    end
    valid_input = 1'b0;
    wait_drain();

    // Reset after byte AD of a word: nothing of it may follow.
    send_word(32'hDEADBEEF);
    repeat (2) @(posedge clk_4f);
    #6 reset = 1'b0;
    #1;
    check("midrst_valid", {31'b0, valid_8}, 32'd0);
    check("midrst_data", {24'b0, data_8}, 32'd0);
    repeat (2) @(posedge clk_4f);
    #2 reset = 1'b1;
    @(posedge clk_4f);
    #1;
    check("post_rst_ready", {31'b0, ready_32}, 32'd1);
    idle(8);
    check("idle_fill", {24'b0, data_8}, {24'b0, IDLE_FILL});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
